// File: rtl/mem_cursor.sv
// mem_cursor: pushbutton-driven address cursor with auto-repeat.
//
// Two raw pushbuttons (increment / decrement) are synchronized and each one
// drives its own IDLE/DELAY/REPEAT auto-repeat FSM. A press gives one step
// at once. Holding the button gives one more step after DELAY_CYC cycles,
// then one step every RATE_CYC cycles until it is released. A synchronous
// load overrides the buttons. The address either wraps or saturates at
// 0 / DEPTH-1, depending on WRAP.
//
// Optional feature: define MEM_CURSOR_DEBOUNCE_EN to add a DB_CYC-cycle
// stability filter after each synchronizer. Without it, the synchronized
// level feeds the FSMs directly.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   inc_button in   raw increment button (asynchronous)
//   dec_button in   raw decrement button (asynchronous)
//   load       in   load request, sampled every cycle
//   load_addr  in   [ADDR_W] address to load (clamped to DEPTH-1)
//   addr       out  [ADDR_W] current registered address
//   delta      out  one-cycle pulse in the first cycle addr is (re)written
//   at_min     out  addr == 0
//   at_max     out  addr == DEPTH-1
module mem_cursor #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int WRAP      = 1,
  parameter int DELAY_CYC = 50000000,
  parameter int RATE_CYC  = 10000000,
  parameter int DB_CYC    = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_button,
  input  logic              dec_button,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              delta,
  output logic              at_min,
  output logic              at_max
);

  localparam int MAX_AB  = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int MAX_CYC = (MAX_AB > DB_CYC) ? MAX_AB : DB_CYC;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  // Counters run 0..LAST, so an event fires on the N-th counted cycle.
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((DELAY_CYC > 1) ? DELAY_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'((RATE_CYC  > 1) ? RATE_CYC  - 1 : 0);
`ifdef MEM_CURSOR_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'((DB_CYC    > 1) ? DB_CYC    - 1 : 0);
`endif
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  function automatic logic [ADDR_W-1:0] clamp_addr(input logic [ADDR_W-1:0] a);
    return (a > MAX_ADDR) ? MAX_ADDR : a;
  endfunction

  logic [1:0] btn_raw;
  logic [1:0] step;  // [0] = increment step, [1] = decrement step

  assign btn_raw = {dec_button, inc_button};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic                sync_p0;
    logic                sync_p1;
    logic                level;
    logic                prev;
    state_t              state;
    logic [CNT_W-1:0]    cnt;

    // Stage p0/p1: two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
      sync_p0 <= btn_raw[g];
      sync_p1 <= sync_p0;
    end

`ifdef MEM_CURSOR_DEBOUNCE_EN
    logic             level_db;
    logic [CNT_W-1:0] db_cnt;

    // Level changes only after DB_CYC consecutive samples disagree with it.
    // Presetting to 1 keeps a button held through reset from looking pressed.
    always_ff @(posedge clk) begin
      if (reset) begin
        level_db <= 1'b1;
        db_cnt   <= '0;
      end else if (sync_p1 == level_db) begin
        db_cnt   <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_db <= sync_p1;
        db_cnt   <= '0;
      end else begin
        db_cnt   <= db_cnt + CNT_W'(1);
      end
    end

    assign level = level_db;
`else
    assign level = sync_p1;
`endif

    // Auto-repeat FSM. prev resets to 1 so that a button held through reset
    // needs a release and a fresh press before it steps.
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        prev  <= 1'b1;
      end else begin
        prev <= level;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (level && !prev) state <= DELAY;
          end
          DELAY: begin
            if (!level) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DLY_LAST) begin
              state <= REPEAT;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!level) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == RATE_LAST) begin
              cnt   <= '0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    // Step is decoded from the current state so that it lands in addr on the
    // same edge the FSM advances. A released button never steps.
    assign step[g] = level && (((state == IDLE)   && !prev)               ||
                               ((state == DELAY)  && (cnt == DLY_LAST))  ||
                               ((state == REPEAT) && (cnt == RATE_LAST)));
  end

  logic [ADDR_W-1:0] next_addr;
  logic              next_delta;

  // Priority: load > step. Simultaneous inc and dec cancel. A saturated
  // bound leaves addr untouched, so delta stays low.
  always_comb begin
    next_addr  = addr;
    next_delta = 1'b0;
    if (load) begin
      next_addr  = clamp_addr(load_addr);
      next_delta = 1'b1;
    end else if (step[0] && !step[1]) begin
      if (addr == MAX_ADDR) begin
        if (WRAP != 0) begin
          next_addr  = '0;
          next_delta = 1'b1;
        end
      end else begin
        next_addr  = addr + ADDR_W'(1);
        next_delta = 1'b1;
      end
    end else if (step[1] && !step[0]) begin
      if (addr == '0) begin
        if (WRAP != 0) begin
          next_addr  = MAX_ADDR;
          next_delta = 1'b1;
        end
      end else begin
        next_addr  = addr - ADDR_W'(1);
        next_delta = 1'b1;
      end
    end
  end

  // Stage p2: output registers; flags are decoded from next_addr so they
  // line up with addr in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      delta  <= 1'b1;
      at_min <= 1'b1;
      at_max <= (DEPTH == 1);
    end else begin
      addr   <= next_addr;
      delta  <= next_delta;
      at_min <= (next_addr == '0);
      at_max <= (next_addr == MAX_ADDR);
    end
  end

endmodule

// File: doc/mem_cursor.md
MEM_CURSOR -- requirements
Module: mem_cursor

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, meaning address width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 1024, meaning the number of valid addresses; legal range 1..2**ADDR_W.
REQ-003 The module SHALL have parameter WRAP, default 1, meaning 1 = wrap-around at the bounds and 0 = saturate at the bounds.
REQ-004 The module SHALL have parameter DELAY_CYC, default 50000000, meaning the number of cycles a button is held before auto-repeat starts.
REQ-005 The module SHALL have parameter RATE_CYC, default 10000000, meaning the number of cycles between auto-repeat steps.
REQ-006 The module SHALL have parameter DB_CYC, default 1000000, meaning the debounce stability window in cycles; it is used only with MEM_CURSOR_DEBOUNCE_EN.
REQ-007 Port clk SHALL be an input, 1 bit wide: the system clock; all logic is on its rising edge.
REQ-008 Port reset SHALL be an input, 1 bit wide: reset, synchronous, active-high.
REQ-009 Port inc_button SHALL be an input, 1 bit wide: raw increment pushbutton, asynchronous to clk.
REQ-010 Port dec_button SHALL be an input, 1 bit wide: raw decrement pushbutton, asynchronous to clk.
REQ-011 Port load SHALL be an input, 1 bit wide: synchronous request to load load_addr, sampled each cycle.
REQ-012 Port load_addr SHALL be an input, ADDR_W bits wide: the address to load.
REQ-013 Port addr SHALL be an output, ADDR_W bits wide: the current registered address.
REQ-014 Port delta SHALL be an output, 1 bit wide: a one-cycle pulse, registered, asserted in the first cycle addr shows a new or reloaded value.
REQ-015 Port at_min SHALL be an output, 1 bit wide: registered, high when addr == 0.
REQ-016 Port at_max SHALL be an output, 1 bit wide: registered, high when addr == DEPTH-1.

Function
REQ-017 Each button SHALL pass through a two-flop synchronizer before any use.
REQ-018 Each button SHALL have its own repeat FSM with states IDLE, DELAY and REPEAT, behaving as follows.
- IDLE -> DELAY: on the rising edge of the conditioned button, emitting one step.
- DELAY -> REPEAT: after DELAY_CYC cycles held, emitting one step.
- In REPEAT: one step every RATE_CYC cycles while held.
- Any state -> IDLE: on release within one cycle, with no step emitted that cycle.
REQ-019 Without debounce, addr and delta SHALL update on the 3rd rising edge at which inc_button/dec_button is sampled high.
REQ-020 Update priority SHALL be reset > load > step.
REQ-021 When an inc step and a dec step occur in the same cycle, they SHALL cancel: addr is unchanged and delta = 0.
REQ-022 For an inc step at DEPTH-1, the result SHALL be 0 when WRAP=1; when WRAP=0 addr is unchanged and delta = 0.
REQ-023 For a dec step at 0, the result SHALL be DEPTH-1 when WRAP=1; when WRAP=0 addr is unchanged and delta = 0.
REQ-024 When load is high, addr SHALL take min(load_addr, DEPTH-1) and delta SHALL be 1, even if the value is unchanged; button steps that cycle are discarded.
REQ-025 Delta SHALL be 1 only in a cycle where addr was written by a step, load or reset; otherwise it is 0.
REQ-026 At_min and at_max SHALL be consistent with addr in the same cycle, with no extra latency; when DEPTH=1 both are high.
REQ-027 All internal counters SHALL be wide enough for max(DELAY_CYC, RATE_CYC, DB_CYC) with no overflow.

Reset
REQ-028 After a clock edge with reset high, the outputs SHALL be addr=0, delta=1, at_min=1, and at_max=1 only when DEPTH=1.
REQ-029 Reset SHALL force both FSMs to IDLE and clear all repeat and debounce counters.
REQ-030 Reset SHALL preset each edge-detector "previous" flop to 1, so a button held through reset produces no step until it is released and pressed again.
REQ-031 While reset is held high, delta SHALL remain 1 and addr SHALL remain 0.

Configuration
REQ-032 With `MEM_CURSOR_DEBOUNCE_EN defined, a synchronized button level SHALL be accepted only after DB_CYC consecutive identical samples, and the REQ-019 latency increases by DB_CYC cycles.
REQ-033 Without `MEM_CURSOR_DEBOUNCE_EN, the synchronized level SHALL feed the FSMs directly, and no debounce logic or DB_CYC counter is synthesized.

Verification
REQ-034 The bench SHALL use DEPTH=10, WRAP=1, DELAY_CYC=8 and RATE_CYC=4, with no debounce, for the scenarios below.
REQ-035 Scenario: reset for 2 cycles -> addr=0, delta=1, at_min=1; then inc pulsed high 1 cycle -> addr=1, delta=1 on the 3rd edge, delta=0 next cycle.
REQ-036 Scenario: inc held for 20 cycles from addr=0 -> steps at t=0, 8, 12, 16 -> addr=4; release -> no further change.
REQ-037 Scenario: addr=9, inc press -> addr=0, delta=1; rerun with WRAP=0 -> addr stays 9, delta=0, at_max=1.
REQ-038 Scenario: inc and dec pressed on the same edge at addr=5 -> addr=5, delta=0; load=1 with load_addr=15 -> addr=9, delta=1.
REQ-039 Scenario: inc held, reset asserted mid-REPEAT, inc still held -> addr=0 with no steps afterwards; release then press -> addr=1.
